// File: rtl/line_buf_pkg.sv
// line_buf_pkg: FSM encoding and ASCII control codes shared by the line assembler.
package line_buf_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } lb_state_e;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] DEL = 8'h7F;

endpackage

// File: rtl/line_buf_mem.sv
// line_buf_mem: DEPTH x N character store, contents are not reset.
// Latency: write lands at the clock edge; read is combinational from the address.
// Backpressure: none; the owner gates i_we.
module line_buf_mem #(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         i_clk,
  input  logic         i_we,
  input  logic [A-1:0] i_waddr,
  input  logic [N-1:0] i_wdata,
  input  logic [A-1:0] i_raddr,
  output logic [N-1:0] o_rdata
);

  logic [N-1:0] mem [2**A];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/line_buf.sv
// line_buf: collects characters until CR or full, then flushes the line in order (LINE_BUF_BS_EN: BS/DEL erase).
// Latency: a CR accepted at edge k presents the first character during cycle k+1; one character per cycle each way.
// Backpressure: reads stall for the whole drain; each write holds stable while i_tx_bsy is high.
module line_buf
  import line_buf_pkg::*;
#(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rx_rdy,
  input  logic [N-1:0] i_rx_data,
  output logic         o_rx_rd,
  output logic         o_tx_wr,
  output logic [N-1:0] o_tx_data,
  input  logic         i_tx_bsy,
  output logic [A:0]   o_len
);

  localparam int         DEPTH    = 1 << A;
  localparam logic [A:0] LEN_FULL = (A+1)'(DEPTH);

  lb_state_e    state_q, state_d;
  logic [A:0]   len_q, len_d;
  logic [A-1:0] rd_ptr_q, rd_ptr_d;
  logic         rx_xfer, tx_xfer;
  logic         mem_we;
  logic         is_cr, is_erase;
  logic [N-1:0] mem_rdata;

  line_buf_mem #(.N(N), .A(A)) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (len_q[A-1:0]),
    .i_wdata (i_rx_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (mem_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_FILL;
      len_q    <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_ptr_d  = rd_ptr_q;
    mem_we    = 1'b0;
    o_rx_rd   = (state_q == ST_FILL) && i_rst_n;
    o_tx_wr   = (state_q == ST_DRAIN);
    o_tx_data = (state_q == ST_DRAIN) ? mem_rdata : '0;
    o_len     = len_q;
    rx_xfer   = (state_q == ST_FILL) && i_rst_n && i_rx_rdy;
    tx_xfer   = (state_q == ST_DRAIN) && !i_tx_bsy;
    is_cr     = (i_rx_data == N'(CR));
`ifdef LINE_BUF_BS_EN
    is_erase  = (i_rx_data == N'(BS)) || (i_rx_data == N'(DEL));
`else
    is_erase  = 1'b0;
`endif

    case (state_q)
      ST_FILL: begin
        if (rx_xfer) begin
          if (is_erase) begin
            // Erase on an empty line is silently dropped.
            if (len_q != '0) begin
              len_d = len_q - 1'b1;
            end
          end else begin
            mem_we = 1'b1;
            len_d  = len_q + 1'b1;
            if (is_cr || (len_d == LEN_FULL)) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (tx_xfer) begin
          if ({1'b0, rd_ptr_q} == (len_q - 1'b1)) begin
            len_d    = '0;
            rd_ptr_d = '0;
            state_d  = ST_FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_line_buf.sv
// tb_line_buf: table vectors plus randomized traffic against a queue-based line model.
module tb_line_buf;

  localparam int N     = 8;
  localparam int A     = 4;
  localparam int DEPTH = 1 << A;
  localparam int NV    = 7;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_rx_rdy;
  logic [N-1:0] i_rx_data;
  logic         o_rx_rd;
  logic         o_tx_wr;
  logic [N-1:0] o_tx_data;
  logic         i_tx_bsy;
  logic [A:0]   o_len;

  line_buf #(.N(N), .A(A)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rx_rdy  (i_rx_rdy),
    .i_rx_data (i_rx_data),
    .o_rx_rd   (o_rx_rd),
    .o_tx_wr   (o_tx_wr),
    .o_tx_data (o_tx_data),
    .i_tx_bsy  (i_tx_bsy),
    .o_len     (o_len)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Strings encode CR as '^', BS as '<', DEL as '~'.
  typedef struct {
    string in_s;
    string exp_s;
    int    bsy;
    int    low;
    int    watch;
  } vec_t;

  vec_t vt [NV];

  int         checks;
  int         errors;
  logic [7:0] src   [$];
  logic [7:0] got   [$];
  logic [7:0] mline [$];
  logic [7:0] exp_q [$];
  int         bsy_mode;
  bit         src_gap;
  int         low_cnt;
  int         n_read;
  int         watch_idx;
  bit         hold_pending;
  logic [7:0] hold_dat;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input byte ch);
    logic [7:0] b;
    b = ch;
    case (b)
      8'h5E:   return 8'h0D;
      8'h3C:   return 8'h08;
      8'h7E:   return 8'h7F;
      default: return b;
    endcase
  endfunction

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) src.push_back(enc(s.getc(i)));
  endtask

  // Line model: a line is released on CR or when it reaches DEPTH characters.
  task automatic model_accept(input logic [7:0] c);
    bit erase;
    erase = 1'b0;
`ifdef LINE_BUF_BS_EN
    erase = (c == 8'h08) || (c == 8'h7F);
`endif
    if (erase) begin
      if (mline.size() > 0) mline.delete(mline.size() - 1);
    end else begin
      mline.push_back(c);
      if (c == 8'h0D || mline.size() == DEPTH) begin
        foreach (mline[i]) exp_q.push_back(mline[i]);
        mline.delete();
      end
    end
  endtask

  task automatic drive_inputs(input bit tx_x);
    i_rx_rdy  = (src.size() > 0) && (!src_gap || $urandom_range(3) != 0);
    i_rx_data = i_rx_rdy ? src[0] : 8'($urandom);
    case (bsy_mode)
      1:       i_tx_bsy = tx_x;
      2:       i_tx_bsy = ($urandom_range(2) == 0);
      default: i_tx_bsy = 1'b0;
    endcase
  endtask

  task automatic run_cycle();
    logic [7:0] c;
    logic [7:0] e;
    bit         rx_x;
    bit         tx_x;
    @(negedge i_clk);
    if (hold_pending) begin
      chk_eq("hold_wr", int'(o_tx_wr), 1);
      chk_eq("hold_dat", int'(o_tx_data), int'(hold_dat));
    end
    rx_x = o_rx_rd && i_rx_rdy;
    tx_x = o_tx_wr && !i_tx_bsy;
    if (!o_rx_rd) low_cnt++;
    if (o_tx_wr) chk_eq("no_read_in_drain", int'(o_rx_rd), 0);
    else         chk_eq("fill_len", int'(o_len), mline.size());
    if (tx_x) begin
      got.push_back(o_tx_data);
      chk_eq("wr_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_eq("wr_dat", int'(o_tx_data), int'(e));
      end
    end
    hold_pending = o_tx_wr && i_tx_bsy;
    hold_dat     = o_tx_data;
    if (rx_x && src.size() > 0) begin
      c = src.pop_front();
      n_read++;
      if (n_read == watch_idx) chk_eq("writes_before_read", got.size(), DEPTH);
      model_accept(c);
    end
    @(posedge i_clk);
    #1;
    drive_inputs(tx_x);
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (!(src.size() == 0 && !o_tx_wr) && n < max_cyc);
    chk_eq("idle_in_budget", int'(src.size() == 0 && !o_tx_wr), 1);
  endtask

  task automatic start_run(input int mode, input bit gap, input int watch);
    bsy_mode     = mode;
    src_gap      = gap;
    watch_idx    = watch;
    low_cnt      = 0;
    n_read       = 0;
    hold_pending = 1'b0;
    got.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int         r;
    int         act;
    checks = 0;
    errors = 0;
    i_rst_n = 1'b0;
    i_rx_rdy = 1'b0;
    i_rx_data = '0;
    i_tx_bsy = 1'b0;
    bsy_mode = 0;
    src_gap = 1'b0;
    hold_pending = 1'b0;

    vt[0] = '{"ab^", "ab^", 0, 3, 0};
    vt[1] = '{"Hi^", "Hi^", 1, 5, 0};
    vt[2] = '{"xxxxxxxxxxxxxxxx^", "xxxxxxxxxxxxxxxx^", 0, 17, 17};
`ifdef LINE_BUF_BS_EN
    vt[3] = '{"ab<c^", "ac^", 0, 3, 0};
    vt[4] = '{"~^", "^", 0, 1, 0};
`else
    vt[3] = '{"ab<c^", "ab<c^", 0, 5, 0};
    vt[4] = '{"~^", "~^", 0, 2, 0};
`endif
    vt[5] = '{"^", "^", 0, 1, 0};
    vt[6] = '{"Hello^", "Hello^", 1, 11, 0};

    repeat (2) @(posedge i_clk);
    #1;
    chk_eq("rst_rx_rd", int'(o_rx_rd), 0);
    chk_eq("rst_tx_wr", int'(o_tx_wr), 0);
    chk_eq("rst_tx_data", int'(o_tx_data), 0);
    chk_eq("rst_len", int'(o_len), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk_eq("post_rst_rx_rd", int'(o_rx_rd), 1);
    chk_eq("post_rst_len", int'(o_len), 0);

    for (int v = 0; v < NV; v++) begin
      start_run(vt[v].bsy, 1'b0, vt[v].watch);
      load(vt[v].in_s);
      drive_inputs(1'b0);
      run_until_idle(200);
      chk_eq("vec_wr_count", got.size(), vt[v].exp_s.len());
      for (int i = 0; i < vt[v].exp_s.len(); i++) begin
        act = (i < got.size()) ? int'(got[i]) : -1;
        chk_eq("vec_wr_byte", act, int'(enc(vt[v].exp_s.getc(i))));
      end
      chk_eq("vec_rd_low_cycles", low_cnt, vt[v].low);
      chk_eq("vec_len_after", int'(o_len), 0);
      chk_eq("vec_model_drained", exp_q.size(), 0);
    end

    // DEL presented on an empty line.
    start_run(0, 1'b0, 0);
    src.push_back(8'h7F);
    drive_inputs(1'b0);
    run_cycle();
`ifdef LINE_BUF_BS_EN
    chk_eq("del_empty_len", int'(o_len), 0);
`else
    chk_eq("del_empty_len", int'(o_len), 1);
`endif
    load("^");
    drive_inputs(1'b0);
    run_until_idle(50);
`ifdef LINE_BUF_BS_EN
    chk_eq("del_empty_writes", got.size(), 1);
`else
    chk_eq("del_empty_writes", got.size(), 2);
`endif

    // Reset in the middle of a drain.
    start_run(0, 1'b0, 0);
    load("abc^");
    drive_inputs(1'b0);
    for (int n = 0; n < 30 && got.size() < 1; n++) run_cycle();
    chk_eq("mid_first_wr", got.size(), 1);
    chk_eq("mid_draining", int'(o_tx_wr), 1);
    i_rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_tx_wr", int'(o_tx_wr), 0);
    chk_eq("mid_rst_tx_data", int'(o_tx_data), 0);
    chk_eq("mid_rst_len", int'(o_len), 0);
    chk_eq("mid_rst_rx_rd", int'(o_rx_rd), 0);
    mline.delete();
    exp_q.delete();
    src.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    start_run(0, 1'b0, 0);
    load("z^");
    drive_inputs(1'b0);
    run_until_idle(50);
    chk_eq("after_rst_count", got.size(), 2);
    act = (got.size() > 0) ? int'(got[0]) : -1;
    chk_eq("after_rst_b0", act, 8'h7A);
    act = (got.size() > 1) ? int'(got[1]) : -1;
    chk_eq("after_rst_b1", act, 8'h0D);

    // Randomized traffic with source gaps and a randomly busy sink.
    start_run(2, 1'b1, 0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 10)      c = 8'h0D;
      else if (r < 14) c = 8'h08;
      else if (r < 17) c = 8'h7F;
      else             c = 8'($urandom_range(126, 32));
      src.push_back(c);
    end
    src.push_back(8'h0D);
    drive_inputs(1'b0);
    run_until_idle(6000);
    chk_eq("rand_model_drained", exp_q.size(), 0);
    chk_eq("rand_line_empty", mline.size(), 0);
    chk_eq("rand_len_after", int'(o_len), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
